// File: rtl/vga_matrix_dac_driver.sv
// VGA timing generator with test-pattern source and per-channel 4x4 current-matrix
// thermometer encoding (rows fully on, one partial row, partial-row columns).
module vga_matrix_dac_driver #(
  parameter int   H_VIS    = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_VIS    = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [11:0] solid_rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic [3:0]  r_row,
  output logic [3:0]  r_sel,
  output logic [3:0]  r_col,
  output logic [3:0]  g_row,
  output logic [3:0]  g_sel,
  output logic [3:0]  g_col,
  output logic [3:0]  b_row,
  output logic [3:0]  b_sel,
  output logic [3:0]  b_col,
  output logic [7:0]  frame
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS_C  = 12'(H_VIS);
  localparam logic [11:0] V_VIS_C  = 12'(V_VIS);
  localparam logic [11:0] HS_FIRST = 12'(H_VIS + H_FP);
  localparam logic [11:0] HS_LAST  = 12'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [11:0] VS_FIRST = 12'(V_VIS + V_FP);
  localparam logic [11:0] VS_LAST  = 12'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [11:0] BAR_W    = 12'd80;
  localparam logic [11:0] ENC_IDLE = 12'h010;

  // Thermometer of n ones from bit 0 upward; bit 3 can never be set for a 2-bit n.
  function automatic logic [3:0] therm(input logic [1:0] n);
    logic [3:0] t;
    for (int i = 0; i < 4; i++) t[i] = (i < int'(n));
    return t;
  endfunction

  // {row, sel, col}: code[3:2] full rows, one-hot partial row, code[1:0] partial cells.
  function automatic logic [11:0] matrix_enc(input logic [3:0] code);
    return {therm(code[3:2]), 4'b0001 << code[3:2], therm(code[1:0])};
  endfunction

  logic [11:0] r_h_p0;
  logic [11:0] r_v_p0;
  logic [7:0]  r_frame_p0;
  logic [1:0]  r_mode_sh;
  logic [11:0] r_rgb_sh;

  logic        w_vld_p0;
  logic        w_h_last;
  logic        w_v_last;
  logic        w_frame_start;
  logic [1:0]  w_mode;
  logic [11:0] w_rgb;
  logic        w_vis;
  logic        w_hs_act;
  logic        w_vs_act;
  logic [11:0] w_bar_full;
  logic [2:0]  w_bar;
  logic [3:0]  w_xor;
  logic [3:0]  w_code_r;
  logic [3:0]  w_code_g;
  logic [3:0]  w_code_b;

  assign w_vld_p0      = en;
  assign w_h_last      = (r_h_p0 == H_LAST);
  assign w_v_last      = (r_v_p0 == V_LAST);
  assign w_frame_start = (r_h_p0 == '0) && (r_v_p0 == '0);

  // Stage p0: raster counters and frame-start shadow registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_p0     <= '0;
      r_v_p0     <= '0;
      r_frame_p0 <= '0;
    end else if (w_vld_p0) begin
      if (w_h_last) begin
        r_h_p0 <= '0;
        if (w_v_last) begin
          r_v_p0     <= '0;
          r_frame_p0 <= r_frame_p0 + 8'd1;
        end else begin
          r_v_p0 <= r_v_p0 + 12'd1;
        end
      end else begin
        r_h_p0 <= r_h_p0 + 12'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode_sh <= '0;
      r_rgb_sh  <= '0;
    end else if (w_vld_p0 && w_frame_start) begin
      r_mode_sh <= mode;
      r_rgb_sh  <= solid_rgb;
    end
  end

  // The first pixel of a frame already uses the settings being latched on that clock.
  assign w_mode = w_frame_start ? mode      : r_mode_sh;
  assign w_rgb  = w_frame_start ? solid_rgb : r_rgb_sh;

  assign w_vis    = (r_h_p0 < H_VIS_C) && (r_v_p0 < V_VIS_C);
  assign w_hs_act = (r_h_p0 >= HS_FIRST) && (r_h_p0 <= HS_LAST);
  assign w_vs_act = (r_v_p0 >= VS_FIRST) && (r_v_p0 <= VS_LAST);

  assign w_bar_full = r_h_p0 / BAR_W;
  assign w_bar      = (w_bar_full > 12'd7) ? 3'd7 : w_bar_full[2:0];
  assign w_xor      = (r_h_p0[7:4] ^ r_v_p0[7:4]) + r_frame_p0[5:2];

  always_comb begin
    w_code_r = '0;
    w_code_g = '0;
    w_code_b = '0;
    if (w_vis) begin
      case (w_mode)
        2'd0: begin
          w_code_r = w_rgb[11:8];
          w_code_g = w_rgb[7:4];
          w_code_b = w_rgb[3:0];
        end
        2'd1: begin
          w_code_r = {4{w_bar[2]}};
          w_code_g = {4{w_bar[1]}};
          w_code_b = {4{w_bar[0]}};
        end
        2'd2: begin
          w_code_r = r_h_p0[8:5];
          w_code_g = r_v_p0[8:5];
          w_code_b = r_h_p0[8:5] ^ r_v_p0[8:5];
        end
        default: begin
          w_code_r = w_xor;
          w_code_g = {w_xor[2:0], w_xor[3]};
          w_code_b = {w_xor[1:0], w_xor[3:2]};
        end
      endcase
    end
  end

  logic        r_hsync_p1;
  logic        r_vsync_p1;
  logic        r_blank_p1;
  logic [11:0] r_enc_r_p1;
  logic [11:0] r_enc_g_p1;
  logic [11:0] r_enc_b_p1;

  // Stage p1: registered sync, blank and cell enables, all from the same counter state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hsync_p1 <= ~SYNC_POL;
      r_vsync_p1 <= ~SYNC_POL;
      r_blank_p1 <= 1'b1;
      r_enc_r_p1 <= ENC_IDLE;
      r_enc_g_p1 <= ENC_IDLE;
      r_enc_b_p1 <= ENC_IDLE;
    end else if (w_vld_p0) begin
      r_hsync_p1 <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vsync_p1 <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_blank_p1 <= ~w_vis;
      r_enc_r_p1 <= matrix_enc(w_code_r);
      r_enc_g_p1 <= matrix_enc(w_code_g);
      r_enc_b_p1 <= matrix_enc(w_code_b);
    end
  end

  assign hsync = r_hsync_p1;
  assign vsync = r_vsync_p1;
  assign blank = r_blank_p1;
  assign r_row = r_enc_r_p1[11:8];
  assign r_sel = r_enc_r_p1[7:4];
  assign r_col = r_enc_r_p1[3:0];
  assign g_row = r_enc_g_p1[11:8];
  assign g_sel = r_enc_g_p1[7:4];
  assign g_col = r_enc_g_p1[3:0];
  assign b_row = r_enc_b_p1[11:8];
  assign b_sel = r_enc_b_p1[7:4];
  assign b_col = r_enc_b_p1[3:0];
  assign frame = r_frame_p0;

endmodule

// File: doc/vga_matrix_dac_driver.md
Name: vga_matrix_dac_driver

Overview:
- Digital source side of the VGA matrix-DAC path: generates VGA timing, produces 4-bit R/G/B pixel codes from a selectable test pattern, and encodes each code into row/column thermometer enables for a 4x4 unit-cell current matrix per channel.
- Sits between the top-level pins (mode/colour inputs) and the analog matrix DACs on ua[].
- Drives hsync/vsync digitally.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, sync active level (0 = active-low)

Ports:
- clk  in  1  pixel clock (25.175 MHz nominal)
- rst  in  1  asynchronous, active-high reset
- en  in  1  advance timing; when low all counters and registered outputs hold
- mode  in  2  pattern select, sampled at frame start
- solid_rgb  in  12  {R,G,B} 4 bits each, used in mode 0, sampled at frame start
- hsync  out  1  horizontal sync, polarity SYNC_POL
- vsync  out  1  vertical sync, polarity SYNC_POL
- blank  out  1  high outside the visible area
- r_row, g_row, b_row  out  4 each  fully-on rows, thermometer: bit i = (i < code[3:2])
- r_sel, g_sel, b_sel  out  4 each  one-hot partial row = code[3:2]
- r_col, g_col, b_col  out  4 each  partial-row columns, thermometer: bit j = (j < code[1:0]); bit 3 always 0
- frame  out  8  frame counter

Behaviour:
- Counters:
  - h counts 0..H_TOTAL-1, where H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800 by default).
  - v increments when h wraps and counts 0..V_TOTAL-1 (525 by default).
  - frame increments by 1 when h and v both wrap on the same clock; it wraps 255->0.
- Timing regions:
  - Visible: h < H_VIS and v < V_VIS.
  - Sync active: h in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1]; v in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1].
- Frame-start latch: mode and solid_rgb are captured into shadow registers on the clock where h=0, v=0 and en=1. Changes mid-frame have no effect until the next frame.
- Pattern code (per channel, 4 bits) computed from the current h, v and shadow registers:
  - Mode 0: shadow solid_rgb.
  - Mode 1: 8 colour bars, bar = h/80, clamped to 7. R = bar[2] ? 15 : 0, G = bar[1] ? 15 : 0, B = bar[0] ? 15 : 0.
  - Mode 2: gradient. R = h[8:5], G = v[8:5], B = h[8:5] XOR v[8:5].
  - Mode 3: animated XOR. Code = (h[7:4] ^ v[7:4]) + frame[5:2], mod 16, on all three channels, with G rotated left 1 and B rotated left 2.
  - When not visible, the code is forced to 0.
- Matrix encoding: active cells = 4*code[3:2] + code[1:0] = code.
  - code 0 -> row=0000, sel=0001, col=0000.
  - code 15 -> row=0111, sel=1000, col=0111.
- Latency: every output is registered. Outputs on cycle n+1 reflect the counter values at cycle n with en=1; sync, blank and cell enables stay mutually aligned.
- Reset (async assert; synchronous release on clk):
  - h=v=0, frame=0, shadow mode=0, shadow colour=0.
  - All cell outputs 0 except sel=0001.
  - blank=1, hsync=vsync at inactive level (~SYNC_POL).
  - First update after release: the cycle with h=0, v=0.
  - Reset mid-frame restarts at h=0, v=0 with no partial-frame frame increment.
- en low: h, v, frame, shadows and all outputs hold their values; a frame-start latch is not taken while en is low.

Test Plan:
- Reset then run 800*525 clocks:
  - hsync low for exactly 96 clocks per line, starting 1 clock after h=656.
  - vsync low for 2 lines starting at line 490.
  - frame = 1 after 420000 en-cycles.
- Mode 0, solid_rgb=0xF70:
  - Visible: r_row=0111, r_sel=1000, r_col=0111; g_row=0001, g_sel=0010, g_col=0111; b_row=0000, b_sel=0001, b_col=0000.
  - Blanked region: all rows and cols 0.
- Mode 1:
  - h=0..79 -> all channels code 0.
  - h=80..159 -> B=15 only.
  - h=560..639 -> all 15.
  - h=640 -> blank=1 one clock later.
- Mode change 0->2 written at line 100 -> no output change until the next h=0, v=0; at h=32, v=0 of the next frame R=1 (r_col=0001).
- en held low 50 clocks mid-line -> all outputs frozen; after en=1 the sequence resumes from the same h with no skipped or duplicated pixel.
- Assert rst at h=300, v=200 for 3 clocks -> blank=1, syncs inactive immediately (async); after release counting restarts at 0,0 and frame is unchanged at 0.
